// File: rtl/sample_in_ball_multi_ctrl_if.sv
// Byte-beat input stream and shuffle-sample output stream for the sample-in-ball controller.
interface sample_in_ball_multi_ctrl_if #(
   parameter int SIB_NUM_SAMPLERS = 4
);
   logic                          data_valid_i;
   logic [SIB_NUM_SAMPLERS*8-1:0] data_i;
   logic                          data_hold_o;
   logic                          sample_valid_o;
   logic                          sample_ready_i;
   logic [7:0]                    sample_i_o;
   logic [7:0]                    sample_j_o;
   logic                          sample_sign_o;

   modport master (
      output data_valid_i, data_i, sample_ready_i,
      input  data_hold_o, sample_valid_o, sample_i_o, sample_j_o, sample_sign_o
   );

   modport slave (
      input  data_valid_i, data_i, sample_ready_i,
      output data_hold_o, sample_valid_o, sample_i_o, sample_j_o, sample_sign_o
   );
endinterface

// File: rtl/sample_in_ball_multi_ctrl.sv
// Sample-in-ball shuffle controller: collects a 64-bit sign prefix, then rejection-samples
// byte lanes into (i, j, sign) triples, several candidate lanes per input beat.
//
// state  | meaning
// IDLE   | waiting for start_i; input held
// SIGN   | consuming sign-prefix beats into sign_buf
// ACTIVE | scanning byte lanes and loading samples
// FLUSH  | last sample loaded, waiting for its handshake
// DONE   | one-cycle done_o pulse, then back to IDLE
module sample_in_ball_multi_ctrl #(
   parameter int SIB_NUM_SAMPLERS = 4,
   parameter int SIB_SAMPLE_W     = 8
) (
   input  logic                           clk,
   input  logic                           rst_b,
   input  logic                           zeroize,
   input  logic                           start_i,
   input  logic [1:0]                     mode_i,
   sample_in_ball_multi_ctrl_if.slave     bus,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           error_o
);
   localparam int N          = SIB_NUM_SAMPLERS;
   localparam int W          = N*SIB_SAMPLE_W;
   localparam int SIGN_BEATS = 64/(N*8);

   typedef enum logic [2:0] {IDLE, SIGN, ACTIVE, FLUSH, DONE} state_t;

   state_t      state;
   logic [N-1:0] mask;
   logic [63:0] sign_buf;
   logic [7:0]  rej_value;
   logic [7:0]  neg_tau;
   logic [3:0]  sign_cnt;
   logic        sample_valid;
   logic [7:0]  sample_i;
   logic [7:0]  sample_j;
   logic        sample_sign;

   logic         found;
   logic         last_lane;
   logic [N-1:0] lowmask;
   logic [7:0]   sel_byte;
   logic         can_load;
   logic         hit;
   logic         last_sample;
   logic         hold;
   logic [7:0]   neg_tau_mode;

   // lowmask covers lanes 0..L of the winning lane so they are never re-examined in this beat
   always_comb begin
      found     = 1'b0;
      last_lane = 1'b0;
      lowmask   = '0;
      sel_byte  = '0;
      for (int l = 0; l < N; l++) begin
         if (!found) begin
            lowmask[l] = 1'b1;
            if (mask[l] && (bus.data_i[l*SIB_SAMPLE_W +: 8] <= rej_value)) begin
               found     = 1'b1;
               sel_byte  = bus.data_i[l*SIB_SAMPLE_W +: 8];
               last_lane = (l == N-1);
            end
         end
      end
   end

   assign can_load    = ~sample_valid | bus.sample_ready_i;
   assign hit         = bus.data_valid_i & found;
   assign last_sample = (rej_value == 8'hFF);

   always_comb begin
      case (state)
         SIGN:    hold = 1'b0;
         ACTIVE: begin
            if (!hit)          hold = 1'b0;
            else if (!can_load) hold = 1'b1;
            else               hold = ~(last_lane | last_sample);
         end
         default: hold = 1'b1;
      endcase
   end

   always_comb begin
      case (mode_i)
         2'd0:    neg_tau_mode = 8'd217;
         2'd1:    neg_tau_mode = 8'd207;
         default: neg_tau_mode = 8'd196;
      endcase
   end

   assign bus.data_hold_o    = hold;
   assign bus.sample_valid_o = sample_valid;
   assign bus.sample_i_o     = sample_i;
   assign bus.sample_j_o     = sample_j;
   assign bus.sample_sign_o  = sample_sign;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state        <= IDLE;
         mask         <= '1;
         sign_buf     <= '0;
         rej_value    <= 8'd196;
         neg_tau      <= 8'd196;
         sign_cnt     <= '0;
         sample_valid <= 1'b0;
         sample_i     <= '0;
         sample_j     <= '0;
         sample_sign  <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
      end else if (zeroize) begin
         state        <= IDLE;
         mask         <= '1;
         sign_buf     <= '0;
         rej_value    <= 8'd196;
         neg_tau      <= 8'd196;
         sign_cnt     <= '0;
         sample_valid <= 1'b0;
         sample_i     <= '0;
         sample_j     <= '0;
         sample_sign  <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
      end else begin
         done_o  <= 1'b0;
         error_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (mode_i != 2'd3) begin
                     neg_tau   <= neg_tau_mode;
                     rej_value <= neg_tau_mode;
                     sign_buf  <= '0;
                     sign_cnt  <= '0;
                     mask      <= '1;
                     busy_o    <= 1'b1;
                     state     <= SIGN;
                  end else begin
                     error_o <= 1'b1;
                  end
               end
            end
            SIGN: begin
               rej_value <= neg_tau;
               if (bus.data_valid_i) begin
                  for (int b = 0; b < SIGN_BEATS; b++) begin
                     if (sign_cnt == 4'(b)) sign_buf[b*W +: W] <= bus.data_i;
                  end
                  if (sign_cnt == 4'(SIGN_BEATS-1)) state <= ACTIVE;
                  else                              sign_cnt <= sign_cnt + 4'd1;
               end
            end
            ACTIVE: begin
               if (hit && can_load) begin
                  sample_valid <= 1'b1;
                  sample_i     <= rej_value;
                  sample_j     <= sel_byte;
                  sample_sign  <= sign_buf[0];
                  sign_buf     <= {1'b0, sign_buf[63:1]};
                  rej_value    <= rej_value + 8'd1;
                  if (last_lane || last_sample) mask <= '1;
                  else                          mask <= mask & ~lowmask;
                  if (last_sample) state <= FLUSH;
               end else begin
                  if (bus.sample_ready_i) sample_valid <= 1'b0;
                  if (bus.data_valid_i && !found) mask <= '1;
               end
            end
            FLUSH: begin
               if (sample_valid && bus.sample_ready_i) begin
                  sample_valid <= 1'b0;
                  done_o       <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sample_in_ball_multi_ctrl.sv
// Directed bench: N=4 and N=8 instances, hand-computed sample sequences and status pulses.
module tb_sample_in_ball_multi_ctrl;
   logic clk = 1'b0;
   logic rst_b;
   logic zeroize, start, zeroize8, start8;
   logic [1:0] mode, mode8;
   logic busy, done, error, busy8, done8, error8;
   int checks = 0;
   int errors = 0;
   int n, dn;
   logic seen;

   always #5 clk = ~clk;

   sample_in_ball_multi_ctrl_if #(.SIB_NUM_SAMPLERS(4)) b4 ();
   sample_in_ball_multi_ctrl_if #(.SIB_NUM_SAMPLERS(8)) b8 ();

   sample_in_ball_multi_ctrl #(.SIB_NUM_SAMPLERS(4), .SIB_SAMPLE_W(8)) dut4 (
      .clk(clk), .rst_b(rst_b), .zeroize(zeroize), .start_i(start), .mode_i(mode),
      .bus(b4.slave), .busy_o(busy), .done_o(done), .error_o(error));

   sample_in_ball_multi_ctrl #(.SIB_NUM_SAMPLERS(8), .SIB_SAMPLE_W(8)) dut8 (
      .clk(clk), .rst_b(rst_b), .zeroize(zeroize8), .start_i(start8), .mode_i(mode8),
      .bus(b8.slave), .busy_o(busy8), .done_o(done8), .error_o(error8));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_b = 1'b0; zeroize = 0; start = 0; mode = 0;
      zeroize8 = 0; start8 = 0; mode8 = 0;
      b4.data_valid_i = 0; b4.data_i = '0; b4.sample_ready_i = 0;
      b8.data_valid_i = 0; b8.data_i = '0; b8.sample_ready_i = 0;
      repeat (3) step();
      chk("rst_valid", b4.sample_valid_o, 0);
      chk("rst_hold", b4.data_hold_o, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_i", b4.sample_i_o, 0);
      chk("rst_j", b4.sample_j_o, 0);
      chk("rst_sign", b4.sample_sign_o, 0);
      rst_b = 1'b1;
      step();

      // illegal mode
      start = 1; mode = 3;
      step();
      start = 0;
      chk("err_pulse", error, 1);
      chk("err_busy", busy, 0);
      step();
      chk("err_clear", error, 0);
      chk("err_busy2", busy, 0);

      // full run, tau=60, all-zero bytes
      start = 1; mode = 2;
      step();
      start = 0;
      chk("m2_busy", busy, 1);
      b4.data_valid_i = 1; b4.data_i = 32'h0000_0001; b4.sample_ready_i = 1;
      #1 chk("m2_sign_hold", b4.data_hold_o, 0);
      step();
      b4.data_i = 32'h0;
      step();
      n = 0;
      for (int c = 0; c < 300 && n < 60; c++) begin
         if (b4.sample_valid_o) begin
            chk("m2_i", b4.sample_i_o, 64'(196 + n));
            chk("m2_j", b4.sample_j_o, 0);
            chk("m2_sign", b4.sample_sign_o, (n == 0) ? 1 : 0);
            n++;
         end
         if (n < 60) step();
      end
      chk("m2_count", n, 60);
      chk("m2_flush_hold", b4.data_hold_o, 1);
      step();
      chk("m2_done", done, 1);
      chk("m2_done_busy", busy, 1);
      step();
      chk("m2_done_clr", done, 0);
      chk("m2_idle_busy", busy, 0);

      // tau=39: multi-lane beat, back-pressure, then zeroize mid-run
      start = 1; mode = 0;
      step();
      start = 0;
      b4.data_i = 32'h0;
      step();
      step();
      b4.data_i = 32'h10FF_05F0;
      #1 chk("m0_hold_l1", b4.data_hold_o, 1);
      step();
      chk("m0_i0", b4.sample_i_o, 217);
      chk("m0_j0", b4.sample_j_o, 8'h05);
      chk("m0_hold_l3", b4.data_hold_o, 0);
      step();
      chk("m0_i1", b4.sample_i_o, 218);
      chk("m0_j1", b4.sample_j_o, 8'h10);
      b4.data_i = 32'h0; b4.sample_ready_i = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("bp_hold", b4.data_hold_o, 1);
         chk("bp_valid", b4.sample_valid_o, 1);
         chk("bp_i", b4.sample_i_o, 218);
         chk("bp_j", b4.sample_j_o, 8'h10);
         step();
      end
      b4.sample_ready_i = 1;
      #1 chk("bp_release_hold", b4.data_hold_o, 1);
      step();
      chk("bp_i_next", b4.sample_i_o, 219);
      chk("bp_j_next", b4.sample_j_o, 0);
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (b4.sample_i_o == 8'd236) seen = 1;
         else step();
      end
      chk("m0_reach_20", seen, 1);
      zeroize = 1;
      step();
      zeroize = 0;
      chk("z_valid", b4.sample_valid_o, 0);
      chk("z_busy", busy, 0);
      chk("z_hold", b4.data_hold_o, 1);
      chk("z_i", b4.sample_i_o, 0);
      chk("z_j", b4.sample_j_o, 0);
      chk("z_sign", b4.sample_sign_o, 0);
      chk("z_done", done, 0);
      step();
      chk("z_stays_idle", busy, 0);

      // restart at tau=49
      start = 1; mode = 1;
      step();
      start = 0;
      step();
      step();
      step();
      chk("m1_valid", b4.sample_valid_o, 1);
      chk("m1_first_i", b4.sample_i_o, 207);
      zeroize = 1;
      step();
      zeroize = 0;
      b4.data_valid_i = 0;

      // N=8, tau=49: single sign beat
      start8 = 1; mode8 = 1;
      step();
      start8 = 0;
      b8.data_valid_i = 1; b8.data_i = 64'h5; b8.sample_ready_i = 1;
      #1 chk("n8_sign_hold", b8.data_hold_o, 0);
      step();
      b8.data_i = 64'h0;
      n = 0; dn = 0;
      for (int c = 0; c < 150; c++) begin
         if (b8.sample_valid_o) begin
            if (n == 0)  chk("n8_first_i", b8.sample_i_o, 207);
            if (n < 3)   chk("n8_sign", b8.sample_sign_o, (n == 1) ? 0 : 1);
            if (n == 48) chk("n8_last_i", b8.sample_i_o, 255);
            n++;
         end
         if (done8) dn++;
         step();
      end
      chk("n8_count", n, 49);
      chk("n8_done_pulses", dn, 1);
      chk("n8_idle", busy8, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sample_in_ball_multi_ctrl.md
SAMPLE_IN_BALL_MULTI_CTRL -- requirements
Module: sample_in_ball_multi_ctrl

Interface
REQ-001 SHALL have parameter SIB_NUM_SAMPLERS, default 4, byte lanes per input beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter SIB_SAMPLE_W, default 8, lane width; 8 is the only legal value.
REQ-003 SHALL derive localparam SIGN_BEATS = 64/(SIB_NUM_SAMPLERS*8), the number of beats in the sign prefix.
REQ-004 SHALL have port clk  input  1  clock; rising edge.
REQ-005 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port zeroize  input  1  synchronous clear of all state.
REQ-007 SHALL have port start_i  input  1  one-cycle start pulse.
REQ-008 SHALL have port mode_i  input  2  parameter set: 0 -> tau=39, 1 -> tau=49, 2 -> tau=60, 3 -> illegal.
REQ-009 SHALL have port data_valid_i  input  1  an input beat is present.
REQ-010 SHALL have port data_i  input  SIB_NUM_SAMPLERS*8  packed byte lanes; lane 0 is the LSBs and the earliest byte.
REQ-011 SHALL have port data_hold_o  output  1  when 1, the current beat is not consumed.
REQ-012 SHALL have port sample_valid_o, sample_ready_i  output/input  1  output valid/ready handshake.
REQ-013 SHALL have port sample_i_o, sample_j_o  output  8  shuffle indices i and j.
REQ-014 SHALL have port sample_sign_o  output  1  sign of coefficient j (1 = negative).
REQ-015 SHALL have port busy_o, done_o, error_o  output  1  status; done_o and error_o are one-cycle pulses.

Function
REQ-016 SHALL implement FSM states IDLE, SIGN, ACTIVE, FLUSH, DONE.
REQ-017 IDLE: on start_i with mode_i<3, SHALL latch tau, clear the sign buffer, and go to SIGN.
REQ-018 IDLE: on start_i with mode_i==3, SHALL pulse error_o and remain in IDLE.
REQ-019 start_i outside IDLE SHALL be ignored; busy_o SHALL be 1 in every state except IDLE.
REQ-020 A beat SHALL be consumed exactly when data_valid_i=1 and data_hold_o=0.
REQ-021 data_hold_o SHALL be 1 in IDLE, FLUSH and DONE.
REQ-022 SIGN: data_hold_o SHALL be 0; consumed beat b (0-based) SHALL write sign bits [b*N*8 +: N*8]; after SIGN_BEATS consumed beats, go to ACTIVE.
REQ-023 SIGN: rej_value SHALL be initialised to 256-tau (8-bit) in the same cycle.
REQ-024 ACTIVE: each cycle, the found lane L SHALL be the lowest lane with mask=1 and data_i[L] <= rej_value; mask resets to all-ones.
REQ-025 ACTIVE: can_load = ~sample_valid_o | sample_ready_i.
REQ-026 ACTIVE, data_valid_i and no lane found: data_hold_o SHALL be 0 (beat consumed, all remaining bytes rejected) and mask SHALL reset.
REQ-027 ACTIVE, lane found and can_load=0: data_hold_o SHALL be 1 and no state SHALL change.
REQ-028 ACTIVE, lane found and can_load=1: load sample_i_o=rej_value, sample_j_o=data_i[L], sample_sign_o=sign_buf[0]; shift sign_buf right by 1; rej_value+1; clear mask bits 0..L.
REQ-029 After a load, data_hold_o SHALL be 0 only if L==N-1 or the load is the last sample; otherwise 1, and the remaining lanes are re-evaluated next cycle against the new rej_value.
REQ-030 The last sample is the load with rej_value==255; it SHALL consume the beat and go to FLUSH; later input bytes are not examined.
REQ-031 FLUSH: when sample_valid_o & sample_ready_i, SHALL go to DONE; DONE SHALL pulse done_o for one cycle, then go to IDLE.
REQ-032 sample_valid_o SHALL clear on ready when no new load occurs, and SHALL stay 1 across back-to-back loads.
REQ-033 Output fields SHALL hold their values while sample_valid_o=1 and sample_ready_i=0.
REQ-034 Exactly tau samples SHALL be emitted per run, with sample_i_o strictly increasing from 256-tau to 255.

Reset
REQ-035 On rst_b=0 or zeroize=1, SHALL set: FSM=IDLE, mask all-ones, sign_buf=0, rej_value=196.
REQ-036 On rst_b=0 or zeroize=1, SHALL set outputs: sample_valid_o=0, sample fields 0, busy_o=0, done_o=0, error_o=0, data_hold_o=1.
REQ-037 zeroize SHALL take priority over every other event, including mid-run, and any pending sample SHALL be dropped.

Verification
REQ-038 Scenario: N=4, mode=2, sign beats 0x00000001, 0x00000000, then all bytes 0x00, ready=1 -> 60 samples with i=196..255 and j=0, first sign=1 then 0; done_o one cycle after the last handshake.
REQ-039 Scenario: mode=0 (tau=39), beat bytes {L0=0xF0, L1=0x05, L2=0xFF, L3=0x10} at i=217 -> L0 rejected; L1 emitted (j=5, hold=1); next cycle L3 emitted (j=0x10, i=218), L2 rejected, beat consumed.
REQ-040 Scenario: sample_ready_i=0 for 10 cycles while a lane qualifies -> data_hold_o=1, outputs stable, rej_value unchanged.
REQ-041 Scenario: start_i with mode_i=3 -> error_o=1 for one cycle, busy_o stays 0.
REQ-042 Scenario: zeroize asserted mid-ACTIVE after 20 samples -> next cycle IDLE with all reset values; a new start at mode=1 emits i from 207.
REQ-043 Scenario: N=8, mode=1 -> sign prefix takes one beat; 49 samples; exactly one done_o pulse.
